// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer.
//   pctrl_state_t : sequencer FSM state encoding (also exported on state_o)
//   latch_ctl_t   : enable/flush pair for one pipeline latch
//   LATCH_*       : index of each latch in a latch_ctl_t array
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } pctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctl_t;

    localparam int N_LATCH  = 4;
    localparam int LATCH_FD = 0;
    localparam int LATCH_DE = 1;
    localparam int LATCH_EM = 2;
    localparam int LATCH_MW = 3;

    function automatic latch_ctl_t latch_ctl(input logic en, input logic flush);
        latch_ctl_t c;
        c.en    = en;
        c.flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Status/control bundle between the datapath and the pipeline sequencer.
//   master : datapath side, drives hazard/cache/halt status, receives enables
//   slave  : sequencer side
//   Inputs  : ihit, dhit, em_dren, em_dwen, de_dren, de_regwr, de_rt, fd_rs,
//             fd_rt, fd_uses_rt, ex_redirect, de_halt, mw_halt
//   Outputs : pc_en, {fd,de,em,mw}_en, {fd,de,em,mw}_flush, halt, state_o,
//             stall_cnt, flush_cnt
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             em_dren;
    logic             em_dwen;
    logic             de_dren;
    logic             de_regwr;
    logic [4:0]       de_rt;
    logic [4:0]       fd_rs;
    logic [4:0]       fd_rt;
    logic             fd_uses_rt;
    logic             ex_redirect;
    logic             de_halt;
    logic             mw_halt;

    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             mw_flush;
    logic             halt;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, em_dren, em_dwen, de_dren, de_regwr, de_rt,
               fd_rs, fd_rt, fd_uses_rt, ex_redirect, de_halt, mw_halt,
        input  pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, mw_flush,
               halt, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, em_dren, em_dwen, de_dren, de_regwr, de_rt,
               fd_rs, fd_rt, fd_uses_rt, ex_redirect, de_halt, mw_halt,
        output pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, mw_flush,
               halt, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the FD instruction needs a register that the load
// in DE has not produced yet. Purely combinational so the forwarding unit can
// share it.
//   de_dren, de_regwr, de_rt : DE-stage load and its destination
//   fd_rs, fd_rt, fd_uses_rt : FD-stage source registers
//   lu_stall                 : one-cycle bubble required
module hazard_detect (
    input  logic       de_dren,
    input  logic       de_regwr,
    input  logic [4:0] de_rt,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rt,
    output logic       lu_stall
);
    // $zero is never a real dependency.
    assign lu_stall = de_dren && de_regwr && (de_rt != 5'd0) &&
                      ((de_rt == fd_rs) || (fd_uses_rt && (de_rt == fd_rt)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the FD/DE/EM/MW latches and the PC of the 5-stage core.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : status inputs and latch/PC controls (pipeline_ctrl_if.slave)
//
// state   | meaning
// RUN     | normal issue; hazards resolved combinationally
// MEMWAIT | data cache miss outstanding, whole pipe frozen
// DRAIN   | halt seen in DE, fetch stopped, older instructions retiring
// HALTED  | halt retired, core frozen until reset
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.slave  bus
);
    pctrl_state_t           state_q, state_d;
    logic                   from_drain_q, from_drain_d;
    logic                   halt_q;
    logic [CNT_W-1:0]       stall_q, flush_q;

    latch_ctl_t [N_LATCH-1:0] ctl;
    logic                   pc_en;
    logic                   redirect_acc;
    logic                   advance;
    logic                   drain_mode;
    logic                   dmiss;
    logic                   lu_stall;
    logic                   stall_inc;

    hazard_detect u_hazard (
        .de_dren    (bus.de_dren),
        .de_regwr   (bus.de_regwr),
        .de_rt      (bus.de_rt),
        .fd_rs      (bus.fd_rs),
        .fd_rt      (bus.fd_rt),
        .fd_uses_rt (bus.fd_uses_rt),
        .lu_stall   (lu_stall)
    );

    assign dmiss = (bus.em_dren || bus.em_dwen) && !bus.dhit;

    always_comb begin
        ctl          = '0;
        pc_en        = 1'b0;
        redirect_acc = 1'b0;
        advance      = 1'b0;
        drain_mode   = 1'b0;
        state_d      = state_q;
        from_drain_d = from_drain_q;

        case (state_q)
            RUN: begin
                if (dmiss) begin
                    state_d      = MEMWAIT;
                    from_drain_d = 1'b0;
                end else begin
                    advance = 1'b1;
                end
            end
            MEMWAIT: begin
                // The dhit cycle itself advances, so the miss costs no extra cycle.
                if (bus.dhit) begin
                    advance    = 1'b1;
                    drain_mode = from_drain_q;
                    state_d    = from_drain_q ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                drain_mode = 1'b1;
                if (dmiss) begin
                    state_d      = MEMWAIT;
                    from_drain_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase

        if (advance) begin
            if (bus.ex_redirect) begin
                // Redirect squashes FD and DE, including any halt sitting in DE.
                pc_en            = 1'b1;
                ctl[LATCH_FD]    = latch_ctl(1'b1, 1'b1);
                ctl[LATCH_DE]    = latch_ctl(1'b1, 1'b1);
                ctl[LATCH_EM]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_MW]    = latch_ctl(1'b1, 1'b0);
                redirect_acc     = 1'b1;
                state_d          = RUN;
            end else if (lu_stall) begin
                ctl[LATCH_DE]    = latch_ctl(1'b1, 1'b1);
                ctl[LATCH_EM]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_MW]    = latch_ctl(1'b1, 1'b0);
            end else if (bus.de_halt) begin
                ctl[LATCH_FD]    = latch_ctl(1'b1, 1'b1);
                ctl[LATCH_DE]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_EM]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_MW]    = latch_ctl(1'b1, 1'b0);
                state_d          = DRAIN;
            end else if (!bus.ihit) begin
                ctl[LATCH_FD]    = latch_ctl(1'b1, 1'b1);
                ctl[LATCH_DE]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_EM]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_MW]    = latch_ctl(1'b1, 1'b0);
            end else begin
                pc_en            = 1'b1;
                ctl[LATCH_FD]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_DE]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_EM]    = latch_ctl(1'b1, 1'b0);
                ctl[LATCH_MW]    = latch_ctl(1'b1, 1'b0);
            end

            // While draining nothing new may be fetched behind the halt.
            if (drain_mode && !bus.ex_redirect) begin
                pc_en               = 1'b0;
                ctl[LATCH_FD].flush = 1'b1;
            end
        end

        // A halt reaching MW stops the core whether or not DE saw it first.
        if (state_q != HALTED && bus.mw_halt) begin
            state_d = HALTED;
        end

        if (RST) begin
            ctl          = '0;
            pc_en        = 1'b0;
            redirect_acc = 1'b0;
        end
    end

    assign stall_inc = !pc_en && (state_q == RUN || state_q == MEMWAIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RUN;
            from_drain_q <= 1'b0;
            halt_q       <= 1'b0;
            stall_q      <= '0;
            flush_q      <= '0;
        end else begin
            state_q      <= state_d;
            from_drain_q <= from_drain_d;
            if (state_d == HALTED) begin
                halt_q <= 1'b1;
            end
            if (stall_inc && stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect_acc && flush_q != {CNT_W{1'b1}}) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en     = pc_en;
    assign bus.fd_en     = ctl[LATCH_FD].en;
    assign bus.de_en     = ctl[LATCH_DE].en;
    assign bus.em_en     = ctl[LATCH_EM].en;
    assign bus.mw_en     = ctl[LATCH_MW].en;
    assign bus.fd_flush  = ctl[LATCH_FD].flush;
    assign bus.de_flush  = ctl[LATCH_DE].flush;
    assign bus.em_flush  = ctl[LATCH_EM].flush;
    assign bus.mw_flush  = ctl[LATCH_MW].flush;
    assign bus.halt      = halt_q;
    assign bus.state_o   = state_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule
